// File: rtl/audio_pkg.sv
// Shared audio constants and types for the tone generators and the I2S blocks.
// Pure definitions: no latency, no flow control.
package audio_pkg;

  localparam int SAMPLE_W       = 24;
  localparam int SLOT_W         = 32;
  localparam int FRAME_BITS     = 64;
  localparam int DATA_FIRST_BIT = 1;

  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int SLOT_IDX_W = $clog2(SLOT_W);

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

  // Bit of a 24-bit word carried at position k of a 32-bit slot (MSB first, zero padded).
  function automatic logic slot_bit(input sample_t word, input logic [SLOT_IDX_W-1:0] k);
    int      ki;
    sample_t sh;
    ki = int'(k);
    if (ki >= DATA_FIRST_BIT && ki < DATA_FIRST_BIT + SAMPLE_W) begin
      sh = word << (ki - DATA_FIRST_BIT);
      return sh[SAMPLE_W-1];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample input and I2S pin bundle for the transmitter.
// The master drives enable and samples; the slave (i2s_tx) drives the strobe and the I2S pins.
interface i2s_tx_if;
  import audio_pkg::*;

  logic    enable;
  sample_t sample_l;
  sample_t sample_r;
  logic    sample_req;
  logic    bclk;
  logic    lrclk;
  logic    sdata;

  modport master (
    output enable, sample_l, sample_r,
    input  sample_req, bclk, lrclk, sdata
  );

  modport slave (
    input  enable, sample_l, sample_r,
    output sample_req, bclk, lrclk, sdata
  );

endinterface

// File: rtl/i2s_clk_div.sv
// BCLK generator: divides sys_clk by 2*CLK_DIV, strobes the edge where bclk rises/falls.
// First rise CLK_DIV cycles after enable is first sampled high; no backpressure.
module i2s_clk_div #(
  parameter int CLK_DIV = 8
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic enable,
  output logic bclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          run;
  logic          term;

  // run holds the counter still on the first enabled edge so the phase is the same after reset or enable rise.
  assign term      = enable && run && (div_cnt == CW'(CLK_DIV - 1));
  assign rise_tick = term && !bclk;
  assign fall_tick = term && bclk;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      run     <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (term) begin
          div_cnt <= '0;
          bclk    <= ~bclk;
        end else begin
          div_cnt <= div_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S stereo transmitter: 32-bit slots, 24 data bits MSB first after a one-bit delay.
// sdata/lrclk update on BCLK falling events; one pair latched per frame with a sample_req pulse; no backpressure.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic    sys_clk,
  input  logic    sys_rst_n,
  i2s_tx_if.slave bus
);

  logic                 fall_tick;
  logic                 unused_rise_tick;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_nxt;
  stereo_t              hold;
  sample_t              slot_word;
  logic                 lrclk_q;
  logic                 sdata_q;
  logic                 sample_req_q;

  i2s_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable    (bus.enable),
    .bclk      (bus.bclk),
    .rise_tick (unused_rise_tick),
    .fall_tick (fall_tick)
  );

  assign bit_nxt   = bit_cnt + BIT_CNT_W'(1);
  assign slot_word = bit_nxt[BIT_CNT_W-1] ? hold.right : hold.left;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt      <= '1;
      hold         <= '0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      sample_req_q <= 1'b0;
    end else if (!bus.enable) begin
      bit_cnt      <= '1;
      hold         <= '0;
      lrclk_q      <= 1'b0;
      sdata_q      <= 1'b0;
      sample_req_q <= 1'b0;
    end else begin
      sample_req_q <= 1'b0;
      if (fall_tick) begin
        bit_cnt <= bit_nxt;
        lrclk_q <= bit_nxt[BIT_CNT_W-1];
        sdata_q <= slot_bit(slot_word, bit_nxt[SLOT_IDX_W-1:0]);
        // Bit 0 is the delay bit, so the new pair is not needed until bit 1.
        if (bit_nxt == '0) begin
          hold.left    <= bus.sample_l;
          hold.right   <= bus.sample_r;
          sample_req_q <= 1'b1;
        end
      end
    end
  end

  assign bus.lrclk      = lrclk_q;
  assign bus.sdata      = sdata_q;
  assign bus.sample_req = sample_req_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx at CLK_DIV=2: stimulus queues expected frames/edges, a monitor checks them.
module tb_i2s_tx;
  import audio_pkg::*;

  localparam int D         = 2;
  localparam int FRAME_CYC = 128 * D;

  typedef struct {
    int          req_cyc;
    logic [63:0] bits;
  } exp_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  i2s_tx_if bus ();

  i2s_tx #(
    .CLK_DIV (D)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int   n_chk       = 0;
  int   n_fail      = 0;
  int   t0          = 0;
  int   last_latch  = 0;
  int   frames_done = 0;
  exp_t exp_q[$];
  int   rise_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_idle(input string name);
    check(name, 64'({bus.bclk, bus.lrclk, bus.sdata, bus.sample_req}), 64'd0);
  endtask

  // Expected 64-bit frame, bit position 0 of the frame in the MSB.
  function automatic logic [63:0] frame_bits(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 24; i++) begin
      f[62 - i] = l[23 - i];
      f[30 - i] = r[23 - i];
    end
    return f;
  endfunction

  // ---------------- monitor ----------------
  logic        capturing  = 1'b0;
  logic        first_rise = 1'b1;
  logic        prev_bclk  = 1'b0;
  logic        prev_lr    = 1'b0;
  logic        have_lr    = 1'b0;
  int          idx        = 0;
  int          lr_rise    = 0;
  exp_t        cur;
  logic [63:0] got_bits;
  logic [63:0] got_lr;

  always @(negedge sys_clk) begin
    if (!sys_rst_n || !bus.enable) begin
      capturing  = 1'b0;
      first_rise = 1'b1;
      have_lr    = 1'b0;
      prev_bclk  = 1'b0;
      prev_lr    = 1'b0;
    end else begin
      if (bus.sample_req) begin
        if (capturing) begin
          n_chk++;
          n_fail++;
          $display("FAIL frame_len: got %0d bits before next sample_req, required 64", idx);
        end
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sample_req: got unexpected pulse at cycle %0d, required none", cyc);
          capturing = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          check("sample_req_cycle", 64'(cyc), 64'(cur.req_cyc));
          capturing = 1'b1;
          idx       = 0;
          got_bits  = '0;
          got_lr    = '0;
        end
      end
      if (bus.bclk && !prev_bclk) begin
        if (first_rise) begin
          first_rise = 1'b0;
          if (rise_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL first_rise: got unexpected startup rise at cycle %0d, required none", cyc);
          end else begin
            check("first_bclk_rise", 64'(cyc), 64'(rise_q.pop_front()));
          end
        end
        if (capturing) begin
          got_bits[63 - idx] = bus.sdata;
          got_lr[63 - idx]   = bus.lrclk;
          idx++;
          if (idx == 64) begin
            check("frame_sdata", got_bits, cur.bits);
            check("frame_lrclk", got_lr, 64'h00000000_FFFFFFFF);
            capturing = 1'b0;
            frames_done++;
          end
        end
      end
      if (bus.lrclk && !prev_lr) begin
        if (have_lr) check("lrclk_period", 64'(cyc - lr_rise), 64'(FRAME_CYC));
        have_lr = 1'b1;
        lr_rise = cyc;
      end
      prev_bclk = bus.bclk;
      prev_lr   = bus.lrclk;
    end
  end

  // ---------------- stimulus ----------------
  // One enabled cycle: queue the expected frame on latch cycles, then optionally perturb sample_l.
  task automatic step_cycle(input int chg);
    int   rel;
    exp_t e;
    @(posedge sys_clk);
    #1;
    rel = cyc - t0;
    if (rel >= 2 * D && (rel - 2 * D) % FRAME_CYC == 0) begin
      e.req_cyc = cyc;
      e.bits    = frame_bits(bus.sample_l, bus.sample_r);
      exp_q.push_back(e);
      last_latch = cyc;
    end
    if (chg > 0 && rel % chg == 0) bus.sample_l = bus.sample_l + 24'h0B1D3F;
  endtask

  task automatic run(input int n, input int chg);
    repeat (n) step_cycle(chg);
  endtask

  task automatic run_until(input int target);
    while (cyc < target) step_cycle(0);
  endtask

  task automatic start();
    @(posedge sys_clk);
    #1;
    bus.enable = 1'b1;
    t0 = cyc + 1;
    rise_q.push_back(t0 + D);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int target;
    bus.enable   = 1'b1;
    bus.sample_l = 24'h111111;
    bus.sample_r = 24'h222222;
    sys_rst_n    = 1'b0;
    repeat (4) begin
      @(posedge sys_clk);
      #1;
      check_idle("reset_hold");
    end

    bus.enable = 1'b0;
    sys_rst_n  = 1'b1;
    repeat (3) begin
      @(posedge sys_clk);
      #1;
      check_idle("enable_low");
    end

    bus.sample_l = 24'hA50FC3;
    bus.sample_r = 24'h123456;
    start();
    run(2 * FRAME_CYC + 8, 0);
    run(4 * FRAME_CYC, 37);

    bus.sample_l = 24'h800000;
    bus.sample_r = 24'h7FFFFF;
    run(2 * FRAME_CYC, 0);

    // Stop during right-slot bit 10 (frame bit 42).
    target = last_latch + FRAME_CYC + 2 * D * 42 + 1;
    run_until(target);
    check("lrclk_before_drop", 64'(bus.lrclk), 64'd1);
    bus.enable = 1'b0;
    @(posedge sys_clk);
    #1;
    check_idle("enable_drop");
    repeat (5) @(posedge sys_clk);
    #1;
    check_idle("enable_drop_hold");

    bus.sample_l = 24'hF00F0F;
    bus.sample_r = 24'h0F0F0F;
    start();
    run(600, 0);

    // Async reset while bclk is high on left-slot bit 1.
    target = last_latch + FRAME_CYC + 2 * D + D;
    run_until(target);
    check("bclk_before_rst", 64'(bus.bclk), 64'd1);
    check("sdata_before_rst", 64'(bus.sdata), 64'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    @(posedge sys_clk);
    #1;
    check_idle("async_rst_hold");

    bus.sample_l = 24'h3C5A96;
    bus.sample_r = 24'hFEDCBA;
    sys_rst_n    = 1'b1;
    t0 = cyc + 1;
    rise_q.push_back(t0 + D);
    run(600, 0);

    bus.enable = 1'b0;
    @(posedge sys_clk);
    #1;
    check_idle("final_idle");
    repeat (3) @(posedge sys_clk);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("rise_q_drained", 64'(rise_q.size()), 64'd0);
    check("frames_seen_min8", 64'(frames_done >= 8), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Downstream stage of the tone generators: takes 24-bit samples (e.g. from the triangle generator's out port) and serialises them to a stereo I2S codec.
- Generates BCLK and LRCLK from sys_clk using an integer divider, and latches one left/right sample pair per frame.
- Signals the latch with a one-cycle sample_req strobe so upstream stages can advance if they need to.
- Standard Philips I2S framing: 32-bit slots, 24 data bits MSB-first, one-BCLK delay after each LRCLK edge.

Parameters:
- CLK_DIV, 8, sys_clk cycles per BCLK half-period; must be ≥1. Frame rate = sys_clk_freq / (128*CLK_DIV), e.g. 50 MHz / 1024 = 48.828 kHz.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  run serialiser; low = idle
- sample_l  in  24  left sample, two's complement
- sample_r  in  24  right sample, two's complement
- sample_req  out  1  one-cycle pulse when a new pair has been latched
- bclk  out  1  I2S bit clock
- lrclk  out  1  word select: 0 = left slot, 1 = right slot
- sdata  out  1  serial data, changes only after BCLK falling events

Behaviour:
- All outputs are registered.
- Reset/idle values (sys_rst_n low, or enable low at a clock edge):
  - bclk=0, lrclk=0, sdata=0, sample_req=0.
  - Internal state: div_cnt=0, bit_cnt=63, holding registers=0.
- Reset is asynchronous: asserting it mid-frame clears state immediately. On release, behaviour matches an enable rise.
- div_cnt counts 0..CLK_DIV-1 while enable=1. At terminal count it wraps to 0 and bclk toggles.
- Falling event = terminal count with bclk==1. On a falling event:
  - bit_cnt increments mod 64.
  - lrclk <= new bit_cnt[5].
  - sdata <= the bit for the new position.
- Slot bit mapping, with k = new bit_cnt[4:0]:
  - k=0: sdata=0 (delay bit).
  - k=1..24: sdata = word[24-k], i.e. MSB at k=1 and LSB at k=24.
  - k=25..31: sdata=0.
  - word = held left sample in the left slot, held right sample in the right slot.
- Frame latch: when new bit_cnt==0, capture sample_l and sample_r into the holding registers in that same edge, and drive sample_req=1 for exactly that one cycle.
  - Input changes at any other time are not seen until the next frame.
- Startup after enable rise (first edge sampling enable=1 counts as cycle 0):
  - First bclk rise at cycle CLK_DIV.
  - First falling event (bit 0, left slot, latch, sample_req) at cycle 2*CLK_DIV.
- Steady state: BCLK period = 2*CLK_DIV; frame = 64 BCLK = 128*CLK_DIV cycles; exactly one sample_req per frame.
- Enable dropped mid-frame: the frame is abandoned and all outputs are at idle values after that edge. No partial-frame completion; the codec sees a truncated frame.
- bit_cnt wraps 63→0 without a gap, so frames are back-to-back.
- CLK_DIV=1: bclk toggles every cycle; all rules above still hold.
- No arithmetic on sample values: bits pass through unmodified and sign is preserved.

Decomposition:
- audio_pkg (shared): SAMPLE_W=24, SLOT_W=32, FRAME_BITS=64, DATA_FIRST_BIT=1. These are reused by the generators and the future RX block.
- One sub-module: i2s_clk_div.
  - Holds div_cnt and the bclk register.
  - Outputs bclk plus rise_tick/fall_tick strobes.
  - Has sync clear on enable low and async clear on sys_rst_n.
- i2s_tx keeps bit_cnt, the holding registers, the output mux and sample_req.

Test Plan:
- Reset: hold sys_rst_n=0 with enable=1 → bclk=0, lrclk=0, sdata=0, sample_req=0 throughout.
- CLK_DIV=2, enable rises, sample_l=24'hA50FC3, sample_r=24'h123456:
  - First bclk rise at cycle 2; sample_req at cycle 4.
  - Capture sdata on bclk rises → left slot bits 1..24 = A50FC3, right slot bits 1..24 = 123456.
  - Bits 0 and 25..31 of each slot = 0.
  - lrclk period = 256 cycles.
- Run 4 frames with CLK_DIV=2, changing sample_l every 37 cycles → exactly one sample_req per 256 cycles; each frame carries the value present at its sample_req cycle.
- Extremes 24'h800000 left, 24'h7FFFFF right → left slot bits 1..24 = 1 followed by 23 zeros; right slot = 0 followed by 23 ones.
- Drop enable during right slot bit 10 → idle outputs on the next cycle. Re-enable → new frame starts with lrclk=0, fresh latch at cycle 2*CLK_DIV.
- Assert sys_rst_n=0 asynchronously mid left slot (between edges) → outputs clear immediately. Release with enable=1 → startup timing identical to the enable-rise case.
